// File: rtl/equiv_miter_monitor.sv
// Cycle-by-cycle equivalence monitor for a golden/candidate output pair, with
// per-side latency alignment, warm-up masking, saturating counters and first-failure capture.
module equiv_miter_monitor #(
   parameter int WIDTH        = 91,
   parameter int LAT_A        = 0,
   parameter int LAT_B        = 0,
   parameter int WARMUP       = 4,
   parameter int CNT_W        = 16,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] y_a,
   input  logic [WIDTH-1:0] y_b,
   output logic             mismatch,
   output logic             fail,
   output logic             halted,
   output logic [CNT_W-1:0] cmp_cnt,
   output logic [CNT_W-1:0] mis_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic [WIDTH-1:0] first_diff
);

   typedef enum logic [1:0] {WARM, RUN, HALT} state_t;

   localparam state_t           RST_STATE = (WARMUP == 0) ? RUN : WARM;
   localparam logic [7:0]       WARM_LAST = 8'(WARMUP);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [WIDTH-1:0] a_dly, b_dly, diff;

   if (LAT_A == 0) begin : g_a_pass
      assign a_dly = y_a;
   end else begin : g_a_line
      logic [WIDTH-1:0] line_q [LAT_A];
      // NOTE: the delay line is reset on purpose so a restarted run never compares stale samples.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < LAT_A; i++) line_q[i] <= '0;
         end else begin
            line_q[0] <= y_a;
            for (int i = 1; i < LAT_A; i++) line_q[i] <= line_q[i-1];
         end
      end
      assign a_dly = line_q[LAT_A-1];
   end

   if (LAT_B == 0) begin : g_b_pass
      assign b_dly = y_b;
   end else begin : g_b_line
      logic [WIDTH-1:0] line_q [LAT_B];
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < LAT_B; i++) line_q[i] <= '0;
         end else begin
            line_q[0] <= y_b;
            for (int i = 1; i < LAT_B; i++) line_q[i] <= line_q[i-1];
         end
      end
      assign b_dly = line_q[LAT_B-1];
   end

   assign diff = a_dly ^ b_dly;

   state_t           state_q, state_d;
   logic [7:0]       warm_q, warm_d;
   logic [CNT_W-1:0] cmp_q, cmp_d, mis_q, mis_d, fidx_q, fidx_d;
   logic [WIDTH-1:0] fdiff_q, fdiff_d;
   logic             fail_q, fail_d, mismatch_q, mismatch_d;

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d    = state_q;
      warm_d     = warm_q;
      cmp_d      = cmp_q;
      mis_d      = mis_q;
      fidx_d     = fidx_q;
      fdiff_d    = fdiff_q;
      fail_d     = fail_q;
      mismatch_d = 1'b0;

      if (clear) begin
         // Clear wins over a same-cycle compare; warm-up neither advances nor completes.
         fail_d  = 1'b0;
         mis_d   = '0;
         fidx_d  = '0;
         fdiff_d = '0;
         if (state_q == HALT) state_d = RUN;
      end else if (en) begin
         unique case (state_q)
            WARM: begin
               warm_d = warm_q + 8'd1;
               if (warm_d == WARM_LAST) state_d = RUN;
            end
            RUN: begin
               if (cmp_q != CNT_MAX) cmp_d = cmp_q + 1'b1;
               if (diff != '0) begin
                  mismatch_d = 1'b1;
                  fail_d     = 1'b1;
                  if (mis_q != CNT_MAX) mis_d = mis_q + 1'b1;
                  if (!fail_q) begin
                     fidx_d  = cmp_q;
                     fdiff_d = diff;
                  end
                  if (STOP_ON_FAIL != 0) state_d = HALT;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         warm_q     <= '0;
         cmp_q      <= '0;
         mis_q      <= '0;
         fidx_q     <= '0;
         fdiff_q    <= '0;
         fail_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         cmp_q      <= cmp_d;
         mis_q      <= mis_d;
         fidx_q     <= fidx_d;
         fdiff_q    <= fdiff_d;
         fail_q     <= fail_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch   = mismatch_q;
   assign fail       = fail_q;
   assign halted     = (state_q == HALT);
   assign cmp_cnt    = cmp_q;
   assign mis_cnt    = mis_q;
   assign first_idx  = fidx_q;
   assign first_diff = fdiff_q;

endmodule
